// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: two-master round-robin arbiter for the shared data bus.
// Master 0 is the CPU data port, master 1 is a DMA/debug master.
// Grants are decoded from a registered state; the bus mux is combinational
// from the master inputs and state, so the CPU path gains no extra latency.
// Optional feature: define ARB_HOLD_LIMIT_EN to build a hold-time counter that
// preempts an owner after MAX_HOLD contended cycles.
module data_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_byteen,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_byteen,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          bus_valid,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_byteen,
  input  logic [DW-1:0] bus_rdata,
  output logic          owner
);

  localparam int unsigned HCW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   owner_q;
  logic   hold_exp;

  // Reject an out-of-range hold limit at elaboration time.
  if (MAX_HOLD == 0 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("data_bus_arbiter: MAX_HOLD must be in 1..255");
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [HCW-1:0] hold_q;
  logic           contended;

  assign contended = ((state_q == OWN0) && m1_req) || ((state_q == OWN1) && m0_req);
  assign hold_exp  = (hold_q >= HCW'(MAX_HOLD));

  // Hold counter: cleared on any state change, counts contended cycles, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (state_d != state_q) begin
      hold_q <= '0;
    end else if (contended && (hold_q != {HCW{1'b1}})) begin
      hold_q <= hold_q + HCW'(1);
    end
  end
`else
  assign hold_exp = 1'b0;
`endif

  // State and last-owner registers; owner starts at 1 so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == OWN0) begin
        owner_q <= 1'b0;
      end else if (state_d == OWN1) begin
        owner_q <= 1'b1;
      end
    end
  end

  // Next-state: round-robin on ties, direct handover, optional preemption.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = owner_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          state_d = m1_req ? OWN1 : IDLE;
        end else if (hold_exp && m1_req) begin
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_d = m0_req ? OWN0 : IDLE;
        end else if (hold_exp && m0_req) begin
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant decode and bus mux; write enable is gated by the owner's req.
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    bus_valid  = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_byteen = '0;
    case (state_q)
      OWN0: begin
        m0_gnt     = 1'b1;
        bus_valid  = m0_req;
        bus_we     = m0_we & m0_req;
        bus_addr   = m0_addr;
        bus_wdata  = m0_wdata;
        bus_byteen = m0_byteen;
      end
      OWN1: begin
        m1_gnt     = 1'b1;
        bus_valid  = m1_req;
        bus_we     = m1_we & m1_req;
        bus_addr   = m1_addr;
        bus_wdata  = m1_wdata;
        bus_byteen = m1_byteen;
      end
      default: ;
    endcase
  end

  assign m0_rdata = bus_rdata;
  assign m1_rdata = bus_rdata;
  assign owner    = owner_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed and randomized bench for data_bus_arbiter with
// a transaction-level model of who owns the bus.
module tb_data_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int MH = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [3:0]    m0_byteen, m1_byteen;
  logic          m0_gnt, m1_gnt;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bus_valid, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [3:0]    bus_byteen;
  logic [DW-1:0] bus_rdata;
  logic          owner;

  int errors = 0;
  int checks = 0;

  // Model: cur = master owning the bus (-1 none), last = last granted master.
  int cur  = -1;
  int last = 1;
  int hold = 0;

  data_bus_arbiter #(.MAX_HOLD(MH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_byteen(bus_byteen), .bus_rdata(bus_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model update: decide the next owner from the request pair at each edge.
  always @(posedge clk or negedge reset) begin
    int r[2];
    int nxt;
    int oth;
    if (!reset) begin
      cur  = -1;
      last = 1;
      hold = 0;
    end else begin
      r[0] = int'(m0_req);
      r[1] = int'(m1_req);
      if (cur < 0) begin
        if (r[0] == 1 && r[1] == 1) nxt = 1 - last;
        else if (r[0] == 1)         nxt = 0;
        else if (r[1] == 1)         nxt = 1;
        else                        nxt = -1;
        oth = 0;
      end else begin
        oth = 1 - cur;
        if (r[cur] == 0)                                 nxt = (r[oth] == 1) ? oth : -1;
        else if (HOLD_EN && hold >= MH && r[oth] == 1)   nxt = oth;
        else                                             nxt = cur;
      end
      if (nxt != cur)                                    hold = 0;
      else if (cur >= 0 && r[oth] == 1 && hold < 255)    hold = hold + 1;
      cur = nxt;
      if (nxt >= 0) last = nxt;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic          e_valid, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [3:0]    e_be;
    e_valid = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    if (cur == 0) begin
      e_valid = m0_req; e_we = m0_we & m0_req; e_addr = m0_addr; e_wdata = m0_wdata; e_be = m0_byteen;
    end else if (cur == 1) begin
      e_valid = m1_req; e_we = m1_we & m1_req; e_addr = m1_addr; e_wdata = m1_wdata; e_be = m1_byteen;
    end
    chk("m0_gnt", 64'(m0_gnt), 64'(cur == 0));
    chk("m1_gnt", 64'(m1_gnt), 64'(cur == 1));
    chk("gnt_onehot", 64'(m0_gnt & m1_gnt), 64'd0);
    chk("owner", 64'(owner), 64'(last));
    chk("bus_valid", 64'(bus_valid), 64'(e_valid));
    chk("bus_we", 64'(bus_we), 64'(e_we));
    chk("bus_addr", 64'(bus_addr), 64'(e_addr));
    chk("bus_wdata", 64'(bus_wdata), 64'(e_wdata));
    chk("bus_byteen", 64'(bus_byteen), 64'(e_be));
    chk("m0_rdata", 64'(m0_rdata), 64'(bus_rdata));
    chk("m1_rdata", 64'(m1_rdata), 64'(bus_rdata));
  end

  initial begin
    int got;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
    bus_rdata = 32'hA5A5_0001;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // Reset state, then single CPU write with one-edge grant latency.
    step();
    chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("rst_m1_gnt", 64'(m1_gnt), 64'd0);
    chk("rst_bus_valid", 64'(bus_valid), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_owner", 64'(owner), 64'd1);
    m0_req = 1; m0_addr = 32'h0000_0100; m0_we = 1; m0_byteen = 4'hF; m0_wdata = 32'h1234_5678;
    #1;
    chk("lat_pre_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("lat_pre_bus_we", 64'(bus_we), 64'd0);
    step();
    chk("lat_m0_gnt", 64'(m0_gnt), 64'd1);
    chk("lat_bus_addr", 64'(bus_addr), 64'h100);
    chk("lat_bus_we", 64'(bus_we), 64'd1);
    chk("lat_owner", 64'(owner), 64'd0);
    m0_req = 0; m0_we = 0;
    step();
    chk("idle_m0_gnt", 64'(m0_gnt), 64'd0);

    // Tie after reset goes to CPU; handover without an IDLE bubble.
    reset = 1'b0; #1; reset = 1'b1;
    m0_req = 1; m1_req = 1;
    step();
    chk("tie_m0_gnt", 64'(m0_gnt), 64'd1);
    chk("tie_m1_gnt", 64'(m1_gnt), 64'd0);
    m0_req = 0;
    step();
    chk("ho_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("ho_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("ho_owner", 64'(owner), 64'd1);

    // DMA write, then req drop with we still high must not write.
    m1_we = 1; m1_addr = 32'h0000_0200; m1_wdata = 32'hDEAD_BEEF; m1_byteen = 4'b0011;
    #1;
    chk("m1w_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
    chk("m1w_byteen", 64'(bus_byteen), 64'h3);
    chk("m1w_we", 64'(bus_we), 64'd1);
    step();
    m1_req = 0;
    #1;
    chk("drop_bus_we", 64'(bus_we), 64'd0);
    chk("drop_m1_gnt", 64'(m1_gnt), 64'd1);
    step();
    chk("drop_idle_m1", 64'(m1_gnt), 64'd0);
    chk("drop_idle_m0", 64'(m0_gnt), 64'd0);
    chk("drop_idle_addr", 64'(bus_addr), 64'd0);
    chk("drop_owner_kept", 64'(owner), 64'd1);
    m1_we = 0;

    // Contention while m1 holds the bus: preempted only with the hold limit.
    m1_req = 1;
    step();
    chk("hold_m1_gnt", 64'(m1_gnt), 64'd1);
    m0_req = 1;
    got = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (m0_gnt && got == 0) got = i;
    end
    chk("hold_first_m0_edge", 64'(got), HOLD_EN ? 64'd5 : 64'd0);
`ifndef ARB_HOLD_LIMIT_EN
    chk("hold_m1_kept", 64'(m1_gnt), 64'd1);
`endif
    m0_req = 0; m1_req = 0;
    step();
    step();

    // Asynchronous reset in the middle of a CPU write.
    m0_req = 1; m0_we = 1; m0_addr = 32'h0000_0300;
    step();
    step();
    chk("arst_pre_gnt", 64'(m0_gnt), 64'd1);
    chk("arst_pre_we", 64'(bus_we), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("arst_bus_we", 64'(bus_we), 64'd0);
    chk("arst_owner", 64'(owner), 64'd1);
    m1_req = 1;
    reset = 1'b1;
    step();
    chk("arst_rel_m0_gnt", 64'(m0_gnt), 64'd1);
    chk("arst_rel_m1_gnt", 64'(m1_gnt), 64'd0);
    m0_req = 0; m1_req = 0; m0_we = 0;
    step();

    // Randomized traffic with sticky requests and rare resets.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 3) == 0) m1_req = ~m1_req;
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_addr = $urandom; m1_addr = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_byteen = 4'($urandom); m1_byteen = 4'($urandom);
      bus_rdata = $urandom;
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end
    reset = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
